// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the single-port memory arbiter.
//   mem_arb_state_e : arbiter FSM states (IDLE, RESP_I, RESP_D)
//   mem_arb_port_e  : requester identity (PORT_I = fetch, PORT_D = load/store)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } mem_arb_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } mem_arb_port_e;

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one synchronous single-port RAM between the CPU fetch port (I) and
// the load/store port (D). Every access is an issue cycle (address/write
// driven to the RAM) followed by a response cycle (one-cycle ready pulse with
// the RAM read data). A port in its response cycle is excluded from issue, so
// the other port can be issued in that same cycle.
//
// Configuration macro: MEM_ARB_RR_EN
//   defined   : round-robin on conflict (port not in last_gnt wins)
//   undefined : fixed priority, D always wins conflicts
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   i_req, iaddr               fetch request / byte address
//   i_ready, idata             fetch completion pulse / data
//   d_req, addr, wdata, wr     load/store request, address, store data, 1=store
//   d_ready, data              load/store completion pulse / load data
//   ram_addr, ram_wdata,       RAM address (unchanged byte address), write
//   ram_we, ram_rdata          data, write enable, read data (1-cycle latency)
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              i_ready,
  output logic [DATA_W-1:0] idata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wr,
  output logic              d_ready,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  mem_arb_state_e state, next_state;
  logic           gnt_wr;       // RESP_D access is a store
  logic           i_elig, d_elig;
  logic           issue;
  mem_arb_port_e  issue_port;

`ifdef MEM_ARB_RR_EN
  mem_arb_port_e  last_gnt;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration, RAM drive, next state and responses.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    i_elig     = 1'b0;
    d_elig     = 1'b0;
    issue      = 1'b0;
    issue_port = PORT_I;
    next_state = IDLE;
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_we     = 1'b0;
    i_ready    = 1'b0;
    idata      = '0;
    d_ready    = 1'b0;
    data       = '0;

    // NOTE: rst_n gates issue and ready combinationally so nothing reaches the
    // RAM (no write on a reset edge) and an abandoned access never pulses
    // ready, even though the state register only clears on the edge.
    if (rst_n) begin
      // The port finishing this cycle still holds req for its old access.
      i_elig = i_req && (state != RESP_I);
      d_elig = d_req && (state != RESP_D);

      if (i_elig && d_elig) begin
        issue = 1'b1;
`ifdef MEM_ARB_RR_EN
        issue_port = (last_gnt == PORT_I) ? PORT_D : PORT_I;
`else
        issue_port = PORT_D;
`endif
      end else if (d_elig) begin
        issue      = 1'b1;
        issue_port = PORT_D;
      end else if (i_elig) begin
        issue      = 1'b1;
        issue_port = PORT_I;
      end

      if (issue) begin
        if (issue_port == PORT_D) begin
          ram_addr   = addr;
          ram_wdata  = wdata;
          ram_we     = wr;
          next_state = RESP_D;
        end else begin
          ram_addr   = iaddr;
          next_state = RESP_I;
        end
      end

      if (state == RESP_I) begin
        i_ready = 1'b1;
        idata   = ram_rdata;
      end
      if (state == RESP_D) begin
        d_ready = 1'b1;
        data    = gnt_wr ? '0 : ram_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State register, store flag and round-robin history.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register update on the edge
    // independent of statement order.
    if (!rst_n) begin
      state  <= IDLE;
      gnt_wr <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_gnt <= PORT_I;
`endif
    end else begin
      state <= next_state;
      if (issue && issue_port == PORT_D) begin
        gnt_wr <= wr;
      end
`ifdef MEM_ARB_RR_EN
      if (issue) begin
        last_gnt <= issue_port;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Table-driven check of mem_arbiter against a behavioural single-port RAM,
// plus hand-written sequences for reset mid-access, saturation and the
// conflict policy selected by MEM_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic [31:0] iaddr;
  logic        i_ready;
  logic [31:0] idata;
  logic        d_req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic        d_ready;
  logic [31:0] data;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .iaddr    (iaddr),
    .i_ready  (i_ready),
    .idata    (idata),
    .d_req    (d_req),
    .addr     (addr),
    .wdata    (wdata),
    .wr       (wr),
    .d_ready  (d_ready),
    .data     (data),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we   (ram_we),
    .ram_rdata(ram_rdata)
  );

  // Behavioural synchronous single-port RAM, word-indexed by addr[11:2].
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[11:2]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[11:2]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [31:0] a, input logic [31:0] wd,
                       input logic w);
    @(negedge clk);
    rst_n = r; i_req = ir; iaddr = ia; d_req = dr; addr = a; wdata = wd; wr = w;
    #2;
  endtask

  typedef struct {
    logic        rst_n;
    logic        i_req;
    logic [31:0] iaddr;
    logic        d_req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        x_i_ready;
    logic [31:0] x_idata;
    logic        x_d_ready;
    logic [31:0] x_data;
    logic [31:0] x_ram_addr;
    logic        x_ram_we;
    logic [31:0] x_ram_wdata;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic ir, input logic [31:0] ia, input logic dr,
    input logic [31:0] a, input logic [31:0] wd, input logic w,
    input logic xir, input logic [31:0] xid, input logic xdr, input logic [31:0] xd,
    input logic [31:0] xra, input logic xwe, input logic [31:0] xwd);
    vec_t v;
    v.rst_n = r; v.i_req = ir; v.iaddr = ia; v.d_req = dr; v.addr = a;
    v.wdata = wd; v.wr = w;
    v.x_i_ready = xir; v.x_idata = xid; v.x_d_ready = xdr; v.x_data = xd;
    v.x_ram_addr = xra; v.x_ram_we = xwe; v.x_ram_wdata = xwd;
    return v;
  endfunction

  vec_t vecs [13];

  initial begin
    logic [31:0] exp_addr;

    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h10 >> 2] = 32'h0000_0013;
    mem[32'h40 >> 2] = 32'hA5A5_A5A5;
    rst_n = 1'b0; i_req = 1'b0; iaddr = '0; d_req = 1'b0; addr = '0; wdata = '0; wr = 1'b0;

    //              rst ir iaddr  dr addr    wdata         wr | ir idata  dr data          ram_addr we ram_wdata
    vecs[0]  = mk(0, 0, 32'h0,  0, 32'h0,   32'h0,        0,  0, 32'h0,  0, 32'h0,        32'h0,   0, 32'h0);
    // store presented during reset: nothing reaches the RAM
    vecs[1]  = mk(0, 0, 32'h0,  1, 32'h40,  32'h55,       1,  0, 32'h0,  0, 32'h0,        32'h0,   0, 32'h0);
    vecs[2]  = mk(1, 0, 32'h0,  0, 32'h0,   32'h0,        0,  0, 32'h0,  0, 32'h0,        32'h0,   0, 32'h0);
    // store 0x100
    vecs[3]  = mk(1, 0, 32'h0,  1, 32'h100, 32'hDEADBEEF, 1,  0, 32'h0,  0, 32'h0,        32'h100, 1, 32'hDEADBEEF);
    vecs[4]  = mk(1, 0, 32'h0,  1, 32'h100, 32'hDEADBEEF, 1,  0, 32'h0,  1, 32'h0,        32'h0,   0, 32'h0);
    // load 0x100
    vecs[5]  = mk(1, 0, 32'h0,  1, 32'h100, 32'h0,        0,  0, 32'h0,  0, 32'h0,        32'h100, 0, 32'h0);
    vecs[6]  = mk(1, 0, 32'h0,  1, 32'h100, 32'h0,        0,  0, 32'h0,  1, 32'hDEADBEEF, 32'h0,   0, 32'h0);
    // single fetch 0x10
    vecs[7]  = mk(1, 1, 32'h10, 0, 32'h0,   32'h0,        0,  0, 32'h0,  0, 32'h0,        32'h10,  0, 32'h0);
    vecs[8]  = mk(1, 1, 32'h10, 0, 32'h0,   32'h0,        0,  1, 32'h13, 0, 32'h0,        32'h0,   0, 32'h0);
    // both request in IDLE (last grant I): D first, I issued in D's response
    vecs[9]  = mk(1, 1, 32'h10, 1, 32'h40,  32'h0,        0,  0, 32'h0,  0, 32'h0,        32'h40,  0, 32'h0);
    vecs[10] = mk(1, 1, 32'h10, 1, 32'h40,  32'h0,        0,  0, 32'h0,  1, 32'hA5A5A5A5, 32'h10,  0, 32'h0);
    vecs[11] = mk(1, 1, 32'h10, 0, 32'h0,   32'h0,        0,  1, 32'h13, 0, 32'h0,        32'h0,   0, 32'h0);
    vecs[12] = mk(1, 0, 32'h0,  0, 32'h0,   32'h0,        0,  0, 32'h0,  0, 32'h0,        32'h0,   0, 32'h0);

    for (int k = 0; k < 13; k++) begin
      drive(vecs[k].rst_n, vecs[k].i_req, vecs[k].iaddr, vecs[k].d_req,
            vecs[k].addr, vecs[k].wdata, vecs[k].wr);
      check($sformatf("v%0d i_ready", k),   {31'b0, i_ready}, {31'b0, vecs[k].x_i_ready});
      check($sformatf("v%0d idata", k),     idata,            vecs[k].x_idata);
      check($sformatf("v%0d d_ready", k),   {31'b0, d_ready}, {31'b0, vecs[k].x_d_ready});
      check($sformatf("v%0d data", k),      data,             vecs[k].x_data);
      check($sformatf("v%0d ram_addr", k),  ram_addr,         vecs[k].x_ram_addr);
      check($sformatf("v%0d ram_we", k),    {31'b0, ram_we},  {31'b0, vecs[k].x_ram_we});
      check($sformatf("v%0d ram_wdata", k), ram_wdata,        vecs[k].x_ram_wdata);
    end

    // ---- Reset mid-access: load abandoned in RESP_D, redone after release ----
    drive(1, 0, 32'h0, 1, 32'h100, 32'h0, 0);
    check("rst_mid issue ram_addr", ram_addr, 32'h100);
    drive(0, 0, 32'h0, 1, 32'h100, 32'h0, 0);
    check("rst_mid no d_ready", {31'b0, d_ready}, 32'h0);
    check("rst_mid no data", data, 32'h0);
    drive(0, 0, 32'h0, 1, 32'h100, 32'h0, 0);
    check("rst_mid idle d_ready", {31'b0, d_ready}, 32'h0);
    check("rst_mid idle i_ready", {31'b0, i_ready}, 32'h0);
    check("rst_mid idle ram_addr", ram_addr, 32'h0);
    check("rst_mid idle ram_we", {31'b0, ram_we}, 32'h0);
    drive(1, 0, 32'h0, 1, 32'h100, 32'h0, 0);
    check("rst_mid reissue ram_addr", ram_addr, 32'h100);
    check("rst_mid reissue d_ready", {31'b0, d_ready}, 32'h0);
    drive(1, 0, 32'h0, 1, 32'h100, 32'h0, 0);
    check("rst_mid done d_ready", {31'b0, d_ready}, 32'h1);
    check("rst_mid done data", data, 32'hDEADBEEF);
    check("rst_mid after store mem", mem[32'h100 >> 2], 32'hDEADBEEF);

    // ---- Saturation: both ports request continuously for 20 cycles ----
    // After reset last_gnt=I, so D wins first; exclusion then forces D,I,D,I.
    drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, 32'h10, 1, 32'h40, 32'h0, 0);
      exp_addr = (k % 2 == 0) ? 32'h40 : 32'h10;
      check($sformatf("sat%0d grant", k), ram_addr, exp_addr);
      check($sformatf("sat%0d i_ready", k), {31'b0, i_ready},
            (k > 0 && k % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("sat%0d d_ready", k), {31'b0, d_ready},
            (k % 2 == 1) ? 32'h1 : 32'h0);
      if (k > 0) begin
        check($sformatf("sat%0d no double ready", k), {31'b0, i_ready & d_ready}, 32'h0);
        check($sformatf("sat%0d rdata", k), i_ready ? idata : data,
              i_ready ? 32'h0000_0013 : 32'hA5A5_A5A5);
      end
    end

    // ---- Conflict policy after a D grant: RR favours I, fixed favours D ----
    drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(1, 0, 32'h0, 1, 32'h40, 32'h0, 0);
    check("policy d alone", ram_addr, 32'h40);
    drive(1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    check("policy d ready", {31'b0, d_ready}, 32'h1);
    drive(1, 1, 32'h10, 1, 32'h40, 32'h0, 0);
`ifdef MEM_ARB_RR_EN
    check("policy conflict winner", ram_addr, 32'h10);
`else
    check("policy conflict winner", ram_addr, 32'h40);
`endif
    drive(1, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    drive(1, 0, 32'h0, 0, 32'h0, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
